// File: rtl/rv32i_control_fsm_pkg.sv
// Shared RV32I types for the multicycle control unit: opcodes, funct3 decodes,
// ALU operations and the datapath mux select encodings.
package rv32i_control_fsm_pkg;

    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned FUNCT3_W  = 3;
    localparam int unsigned FUNCT7_W  = 7;
    localparam int unsigned LSB_W     = 2;
    localparam int unsigned MASK_W    = 4;
    localparam int unsigned PCMUX_W   = 2;
    localparam int unsigned ALUMUX2_W = 3;
    localparam int unsigned RFMUX_W   = 4;
    localparam int unsigned ALUOP_W   = 3;

    typedef enum logic [OPCODE_W-1:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    // Encoded so that an arithmetic funct3 maps straight onto the ALU op.
    typedef enum logic [ALUOP_W-1:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [FUNCT3_W-1:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [FUNCT3_W-1:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [FUNCT3_W-1:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [FUNCT3_W-1:0] {
        f3_add  = 3'b000,
        f3_sll  = 3'b001,
        f3_slt  = 3'b010,
        f3_sltu = 3'b011,
        f3_xor  = 3'b100,
        f3_sr   = 3'b101,
        f3_or   = 3'b110,
        f3_and  = 3'b111
    } arith_funct3_t;

    typedef enum logic [PCMUX_W-1:0] {
        pcmux_pc_plus4 = 2'd0,
        pcmux_alu_out  = 2'd1,
        pcmux_alu_mod2 = 2'd2
    } pcmux_sel_t;

    typedef enum logic {
        marmux_pc_out  = 1'b0,
        marmux_alu_out = 1'b1
    } marmux_sel_t;

    typedef enum logic {
        cmpmux_rs2_out = 1'b0,
        cmpmux_i_imm   = 1'b1
    } cmpmux_sel_t;

    typedef enum logic {
        alumux1_rs1_out = 1'b0,
        alumux1_pc_out  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [ALUMUX2_W-1:0] {
        alumux2_i_imm   = 3'd0,
        alumux2_u_imm   = 3'd1,
        alumux2_b_imm   = 3'd2,
        alumux2_s_imm   = 3'd3,
        alumux2_j_imm   = 3'd4,
        alumux2_rs2_out = 3'd5
    } alumux2_sel_t;

    typedef enum logic [RFMUX_W-1:0] {
        rf_alu_out  = 4'd0,
        rf_br_en    = 4'd1,
        rf_u_imm    = 4'd2,
        rf_lw       = 4'd3,
        rf_pc_plus4 = 4'd4,
        rf_lb       = 4'd5,
        rf_lbu      = 4'd6,
        rf_lh       = 4'd7,
        rf_lhu      = 4'd8
    } regfilemux_sel_t;

endpackage

// File: rtl/rv32i_store_mask.sv
// Write byte-lane mask for a store; lanes shifted past bit 3 are simply dropped.
module rv32i_store_mask
    import rv32i_control_fsm_pkg::*;
(
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [LSB_W-1:0]    addr_lsb,
    output logic [MASK_W-1:0]   byte_enable_c
);

    always_comb begin
        byte_enable_c = 4'hF;
        case (funct3)
            sb:      byte_enable_c = MASK_W'(4'b0001 << addr_lsb);
            sh:      byte_enable_c = MASK_W'(4'b0011 << addr_lsb);
            default: byte_enable_c = 4'hF;
        endcase
    end

endmodule

// File: rtl/rv32i_control_fsm.sv
// Multicycle RV32I control unit: sequences fetch, decode, execute, memory and
// writeback one instruction at a time; outputs decode from state and IR fields.
module rv32i_control_fsm
    import rv32i_control_fsm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [FUNCT3_W-1:0]  funct3,
    input  logic [FUNCT7_W-1:0]  funct7,
    input  logic                 br_en,
    input  logic [LSB_W-1:0]     addr_lsb,
    input  logic                 mem_resp,
    output logic                 load_pc,
    output logic                 load_ir,
    output logic                 load_regfile,
    output logic                 load_mar,
    output logic                 load_mdr,
    output logic                 load_data_out,
    output logic [PCMUX_W-1:0]   pcmux_sel,
    output logic                 marmux_sel,
    output logic                 cmpmux_sel,
    output logic                 alumux1_sel,
    output logic [ALUMUX2_W-1:0] alumux2_sel,
    output logic [RFMUX_W-1:0]   regfilemux_sel,
    output logic [ALUOP_W-1:0]   aluop,
    output logic [FUNCT3_W-1:0]  cmpop,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [MASK_W-1:0]    mem_byte_enable
);

    typedef enum logic [3:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_LUI, S_AUIPC, S_JAL, S_JALR, S_BR, S_IMM, S_REG,
        S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2
    } state_t;

    state_t          state;
    state_t          next_state;
    pcmux_sel_t      pcmux;
    marmux_sel_t     marmux;
    cmpmux_sel_t     cmpmux;
    alumux1_sel_t    alumux1;
    alumux2_sel_t    alumux2;
    regfilemux_sel_t regfilemux;
    alu_ops          alu_op;
    branch_funct3_t  cmp_op;
    logic [MASK_W-1:0] store_mask_c;
    logic            unused_funct7;

    // Only funct7[5] distinguishes sub/sra from add/srl.
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Execute state selected by the opcode; unknown opcodes fall back to fetch.
    function automatic state_t decode_target(input logic [OPCODE_W-1:0] op);
        case (op)
            op_lui:   return S_LUI;
            op_auipc: return S_AUIPC;
            op_jal:   return S_JAL;
            op_jalr:  return S_JALR;
            op_br:    return S_BR;
            op_load:  return S_CALC_ADDR;
            op_store: return S_CALC_ADDR;
            op_imm:   return S_IMM;
            op_reg:   return S_REG;
            default:  return S_FETCH1;
        endcase
    endfunction

    rv32i_store_mask u_store_mask (
        .funct3        (funct3),
        .addr_lsb      (addr_lsb),
        .byte_enable_c (store_mask_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH1;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH1:    next_state = S_FETCH2;
            S_FETCH2:    if (mem_resp) next_state = S_FETCH3;
            S_FETCH3:    next_state = S_DECODE;
            S_DECODE:    next_state = decode_target(opcode);
            S_CALC_ADDR: next_state = (opcode == op_store) ? S_ST1 : S_LD1;
            S_LD1:       if (mem_resp) next_state = S_LD2;
            S_ST1:       if (mem_resp) next_state = S_ST2;
            default:     next_state = S_FETCH1;
        endcase
    end

    always_comb begin
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'hF;
        pcmux           = pcmux_pc_plus4;
        marmux          = marmux_pc_out;
        cmpmux          = cmpmux_rs2_out;
        alumux1         = alumux1_rs1_out;
        alumux2         = alumux2_i_imm;
        regfilemux      = rf_alu_out;
        alu_op          = alu_add;
        cmp_op          = beq;
        case (state)
            S_FETCH1: begin
                marmux   = marmux_pc_out;
                load_mar = 1'b1;
            end
            S_FETCH2: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
            end
            S_FETCH3: load_ir = 1'b1;
            S_DECODE: load_pc = (decode_target(opcode) == S_FETCH1);
            S_LUI: begin
                regfilemux   = rf_u_imm;
                load_regfile = 1'b1;
                load_pc      = 1'b1;
            end
            S_AUIPC: begin
                alumux1      = alumux1_pc_out;
                alumux2      = alumux2_u_imm;
                alu_op       = alu_add;
                load_regfile = 1'b1;
                load_pc      = 1'b1;
            end
            S_IMM, S_REG: begin
                alumux2      = (state == S_REG) ? alumux2_rs2_out : alumux2_i_imm;
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                case (funct3)
                    f3_slt, f3_sltu: begin
                        cmpmux     = (state == S_REG) ? cmpmux_rs2_out : cmpmux_i_imm;
                        cmp_op     = (funct3 == f3_slt) ? blt : bltu;
                        regfilemux = rf_br_en;
                    end
                    f3_sr:   alu_op = funct7[5] ? alu_sra : alu_srl;
                    f3_add:  alu_op = (state == S_REG && funct7[5]) ? alu_sub : alu_add;
                    default: alu_op = alu_ops'(funct3);
                endcase
            end
            S_BR: begin
                cmp_op  = branch_funct3_t'(funct3);
                alumux1 = alumux1_pc_out;
                alumux2 = alumux2_b_imm;
                pcmux   = br_en ? pcmux_alu_out : pcmux_pc_plus4;
                load_pc = 1'b1;
            end
            S_JAL: begin
                regfilemux   = rf_pc_plus4;
                load_regfile = 1'b1;
                alumux1      = alumux1_pc_out;
                alumux2      = alumux2_j_imm;
                pcmux        = pcmux_alu_out;
                load_pc      = 1'b1;
            end
            S_JALR: begin
                regfilemux   = rf_pc_plus4;
                load_regfile = 1'b1;
                alumux2      = alumux2_i_imm;
                pcmux        = pcmux_alu_mod2;
                load_pc      = 1'b1;
            end
            S_CALC_ADDR: begin
                marmux   = marmux_alu_out;
                load_mar = 1'b1;
                if (opcode == op_store) begin
                    alumux2       = alumux2_s_imm;
                    load_data_out = 1'b1;
                end else begin
                    alumux2 = alumux2_i_imm;
                end
            end
            S_LD1: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
            end
            S_LD2: begin
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                case (funct3)
                    lb:      regfilemux = rf_lb;
                    lh:      regfilemux = rf_lh;
                    lbu:     regfilemux = rf_lbu;
                    lhu:     regfilemux = rf_lhu;
                    default: regfilemux = rf_lw;
                endcase
            end
            S_ST1: begin
                mem_write       = 1'b1;
                mem_byte_enable = store_mask_c;
            end
            S_ST2: load_pc = 1'b1;
            default: load_pc = 1'b0;
        endcase
    end

    assign pcmux_sel      = pcmux;
    assign marmux_sel     = marmux;
    assign cmpmux_sel     = cmpmux;
    assign alumux1_sel    = alumux1;
    assign alumux2_sel    = alumux2;
    assign regfilemux_sel = regfilemux;
    assign aluop          = alu_op;
    assign cmpop          = cmp_op;

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Directed bench for the RV32I control FSM: expected control vectors are queued
// as each step is driven and compared after the following clock edge.
module tb_rv32i_control_fsm;
    import rv32i_control_fsm_pkg::*;

    typedef struct packed {
        logic       load_pc;
        logic       load_ir;
        logic       load_regfile;
        logic       load_mar;
        logic       load_mdr;
        logic       load_data_out;
        logic [1:0] pcmux;
        logic       marmux;
        logic       cmpmux;
        logic       alumux1;
        logic [2:0] alumux2;
        logic [3:0] regfilemux;
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] mbe;
    } ctl_t;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       br_en;
    logic [1:0] addr_lsb;
    logic       mem_resp;
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic [1:0] pcmux_sel;
    logic       marmux_sel, cmpmux_sel, alumux1_sel;
    logic [2:0] alumux2_sel;
    logic [3:0] regfilemux_sel;
    logic [2:0] aluop, cmpop;
    logic       mem_read, mem_write;
    logic [3:0] mem_byte_enable;

    ctl_t  exp_q[$];
    string tag_q[$];
    int    n_cmp;
    int    n_bad;

    rv32i_control_fsm dut (
        .clk             (clk),
        .rst             (rst),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7          (funct7),
        .br_en           (br_en),
        .addr_lsb        (addr_lsb),
        .mem_resp        (mem_resp),
        .load_pc         (load_pc),
        .load_ir         (load_ir),
        .load_regfile    (load_regfile),
        .load_mar        (load_mar),
        .load_mdr        (load_mdr),
        .load_data_out   (load_data_out),
        .pcmux_sel       (pcmux_sel),
        .marmux_sel      (marmux_sel),
        .cmpmux_sel      (cmpmux_sel),
        .alumux1_sel     (alumux1_sel),
        .alumux2_sel     (alumux2_sel),
        .regfilemux_sel  (regfilemux_sel),
        .aluop           (aluop),
        .cmpop           (cmpop),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t dflt();
        ctl_t e;
        e            = '0;
        e.pcmux      = pcmux_pc_plus4;
        e.marmux     = marmux_pc_out;
        e.cmpmux     = cmpmux_rs2_out;
        e.alumux1    = alumux1_rs1_out;
        e.alumux2    = alumux2_i_imm;
        e.regfilemux = rf_alu_out;
        e.aluop      = alu_add;
        e.cmpop      = beq;
        e.mbe        = 4'hF;
        return e;
    endfunction

    function automatic ctl_t e_fetch1();
        ctl_t e;
        e          = dflt();
        e.marmux   = marmux_pc_out;
        e.load_mar = 1'b1;
        return e;
    endfunction

    function automatic logic known_op(input logic [6:0] op);
        case (op)
            op_lui, op_auipc, op_jal, op_jalr, op_br,
            op_load, op_store, op_imm, op_reg: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctl_t observe();
        ctl_t o;
        o.load_pc       = load_pc;
        o.load_ir       = load_ir;
        o.load_regfile  = load_regfile;
        o.load_mar      = load_mar;
        o.load_mdr      = load_mdr;
        o.load_data_out = load_data_out;
        o.pcmux         = pcmux_sel;
        o.marmux        = marmux_sel;
        o.cmpmux        = cmpmux_sel;
        o.alumux1       = alumux1_sel;
        o.alumux2       = alumux2_sel;
        o.regfilemux    = regfilemux_sel;
        o.aluop         = aluop;
        o.cmpop         = cmpop;
        o.mem_read      = mem_read;
        o.mem_write     = mem_write;
        o.mbe           = mem_byte_enable;
        return o;
    endfunction

    task automatic compare_front();
        ctl_t  e;
        ctl_t  o;
        string t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0d entries expected >0", exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observe();
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
        end
    endtask

    // Queue the expectation for the state entered at the next edge, clock, check.
    task automatic step(input ctl_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    // From FETCH1: FETCH2 (d-cycle response delay), FETCH3, DECODE.
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int d, input string nm);
        ctl_t e;
        int   rd;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        mem_resp = 1'b0;
        e          = dflt();
        e.mem_read = 1'b1;
        e.load_mdr = 1'b1;
        step(e, {nm, ":fetch2"});
        rd = int'(mem_read);
        for (int i = 0; i < d; i++) begin
            step(e, {nm, ":fetch2_wait"});
            rd += int'(mem_read);
        end
        mem_resp = 1'b1;
        e         = dflt();
        e.load_ir = 1'b1;
        step(e, {nm, ":fetch3"});
        mem_resp = 1'b0;
        n_cmp++;
        assert (rd === d + 1) else begin
            n_bad++;
            $error("FAIL %s:read_cycles observed %0d expected %0d", nm, rd, d + 1);
        end
        e         = dflt();
        e.load_pc = !known_op(op);
        step(e, {nm, ":decode"});
    endtask

    task automatic arith(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [2:0] exp_alu, input string nm);
        ctl_t e;
        fetch(op, f3, f7, 0, nm);
        e              = dflt();
        e.alumux2      = (op == op_reg) ? alumux2_rs2_out : alumux2_i_imm;
        e.aluop        = exp_alu;
        e.load_regfile = 1'b1;
        e.load_pc      = 1'b1;
        step(e, {nm, ":exec"});
        step(e_fetch1(), {nm, ":fetch1"});
    endtask

    task automatic store(input logic [2:0] f3, input logic [1:0] lsb, input logic [3:0] exp_mbe,
                         input string nm);
        ctl_t e;
        fetch(op_store, f3, 7'h00, 0, nm);
        addr_lsb        = lsb;
        e               = dflt();
        e.marmux        = marmux_alu_out;
        e.load_mar      = 1'b1;
        e.alumux2       = alumux2_s_imm;
        e.load_data_out = 1'b1;
        step(e, {nm, ":calc_addr"});
        e           = dflt();
        e.mem_write = 1'b1;
        e.mbe       = exp_mbe;
        step(e, {nm, ":st1"});
        step(e, {nm, ":st1_wait"});
        mem_resp  = 1'b1;
        e         = dflt();
        e.load_pc = 1'b1;
        step(e, {nm, ":st2"});
        mem_resp = 1'b0;
        step(e_fetch1(), {nm, ":fetch1"});
    endtask

    task automatic load(input logic [2:0] f3, input logic [3:0] exp_rf, input string nm);
        ctl_t e;
        fetch(op_load, f3, 7'h00, 1, nm);
        e          = dflt();
        e.marmux   = marmux_alu_out;
        e.load_mar = 1'b1;
        e.alumux2  = alumux2_i_imm;
        step(e, {nm, ":calc_addr"});
        e          = dflt();
        e.mem_read = 1'b1;
        e.load_mdr = 1'b1;
        step(e, {nm, ":ld1"});
        mem_resp       = 1'b1;
        e              = dflt();
        e.regfilemux   = exp_rf;
        e.load_regfile = 1'b1;
        e.load_pc      = 1'b1;
        step(e, {nm, ":ld2"});
        mem_resp = 1'b0;
        step(e_fetch1(), {nm, ":fetch1"});
    endtask

    initial begin
        ctl_t e;
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        opcode   = 7'h00;
        funct3   = 3'd0;
        funct7   = 7'h00;
        br_en    = 1'b0;
        addr_lsb = 2'd0;
        mem_resp = 1'b0;
        step(e_fetch1(), "reset");
        rst = 1'b0;

        // addi x1,x0,5 with a slow instruction fetch
        fetch(op_imm, 3'd0, 7'h00, 5, "addi");
        e              = dflt();
        e.alumux2      = alumux2_i_imm;
        e.aluop        = alu_add;
        e.load_regfile = 1'b1;
        e.load_pc      = 1'b1;
        step(e, "addi:imm");
        step(e_fetch1(), "addi:fetch1");

        // Branch taken / not taken
        for (int t = 1; t >= 0; t--) begin
            fetch(op_br, 3'd0, 7'h00, 0, "beq");
            br_en     = (t == 1);
            e         = dflt();
            e.cmpop   = beq;
            e.alumux1 = alumux1_pc_out;
            e.alumux2 = alumux2_b_imm;
            e.pcmux   = (t == 1) ? pcmux_alu_out : pcmux_pc_plus4;
            e.load_pc = 1'b1;
            step(e, (t == 1) ? "beq_taken:br" : "beq_not_taken:br");
            step(e_fetch1(), "beq:fetch1");
        end
        br_en = 1'b0;

        // bltu, cmpop follows funct3
        fetch(op_br, 3'd6, 7'h00, 0, "bltu");
        e         = dflt();
        e.cmpop   = bltu;
        e.alumux1 = alumux1_pc_out;
        e.alumux2 = alumux2_b_imm;
        e.load_pc = 1'b1;
        step(e, "bltu:br");
        step(e_fetch1(), "bltu:fetch1");

        store(3'd0, 2'd2, 4'b0100, "sb_lsb2");
        store(3'd1, 2'd2, 4'b1100, "sh_lsb2");
        store(3'd1, 2'd3, 4'b1000, "sh_lsb3");
        store(3'd2, 2'd1, 4'hF,    "sw_lsb1");
        store(3'd0, 2'd3, 4'b1000, "sb_lsb3");

        load(3'd4, rf_lbu, "lbu");
        load(3'd2, rf_lw,  "lw");
        load(3'd1, rf_lh,  "lh");

        arith(op_reg, 3'd0, 7'h00, alu_add, "add");
        arith(op_reg, 3'd0, 7'h20, alu_sub, "sub");
        arith(op_imm, 3'd5, 7'h20, alu_sra, "srai");
        arith(op_imm, 3'd5, 7'h00, alu_srl, "srli");
        arith(op_imm, 3'd0, 7'h7F, alu_add, "addi_neg");
        arith(op_reg, 3'd7, 7'h00, alu_and, "and");
        arith(op_imm, 3'd1, 7'h00, alu_sll, "slli");

        // slti / sltu select the comparator path
        fetch(op_imm, 3'd2, 7'h00, 0, "slti");
        e              = dflt();
        e.alumux2      = alumux2_i_imm;
        e.cmpmux       = cmpmux_i_imm;
        e.cmpop        = blt;
        e.regfilemux   = rf_br_en;
        e.load_regfile = 1'b1;
        e.load_pc      = 1'b1;
        step(e, "slti:imm");
        step(e_fetch1(), "slti:fetch1");
        fetch(op_reg, 3'd3, 7'h00, 0, "sltu");
        e.alumux2 = alumux2_rs2_out;
        e.cmpmux  = cmpmux_rs2_out;
        e.cmpop   = bltu;
        step(e, "sltu:reg");
        step(e_fetch1(), "sltu:fetch1");

        fetch(op_lui, 3'd0, 7'h00, 0, "lui");
        e              = dflt();
        e.regfilemux   = rf_u_imm;
        e.load_regfile = 1'b1;
        e.load_pc      = 1'b1;
        step(e, "lui:exec");
        step(e_fetch1(), "lui:fetch1");

        fetch(op_auipc, 3'd0, 7'h00, 0, "auipc");
        e              = dflt();
        e.alumux1      = alumux1_pc_out;
        e.alumux2      = alumux2_u_imm;
        e.load_regfile = 1'b1;
        e.load_pc      = 1'b1;
        step(e, "auipc:exec");
        step(e_fetch1(), "auipc:fetch1");

        fetch(op_jal, 3'd0, 7'h00, 0, "jal");
        e              = dflt();
        e.regfilemux   = rf_pc_plus4;
        e.load_regfile = 1'b1;
        e.alumux1      = alumux1_pc_out;
        e.alumux2      = alumux2_j_imm;
        e.pcmux        = pcmux_alu_out;
        e.load_pc      = 1'b1;
        step(e, "jal:exec");
        step(e_fetch1(), "jal:fetch1");

        fetch(op_jalr, 3'd0, 7'h00, 0, "jalr");
        e              = dflt();
        e.regfilemux   = rf_pc_plus4;
        e.load_regfile = 1'b1;
        e.alumux2      = alumux2_i_imm;
        e.pcmux        = pcmux_alu_mod2;
        e.load_pc      = 1'b1;
        step(e, "jalr:exec");
        step(e_fetch1(), "jalr:fetch1");

        // Unknown opcode: DECODE advances the PC and returns straight to FETCH1
        fetch(7'h7F, 3'd0, 7'h00, 0, "op7f");
        step(e_fetch1(), "op7f:fetch1");

        // Reset held two cycles in the middle of a load wait; a late response is ignored
        fetch(op_load, 3'd2, 7'h00, 0, "rst_ld");
        e          = dflt();
        e.marmux   = marmux_alu_out;
        e.load_mar = 1'b1;
        step(e, "rst_ld:calc_addr");
        e          = dflt();
        e.mem_read = 1'b1;
        e.load_mdr = 1'b1;
        step(e, "rst_ld:ld1");
        step(e, "rst_ld:ld1_wait");
        rst = 1'b1;
        step(e_fetch1(), "rst_ld:reset1");
        mem_resp = 1'b1;
        step(e_fetch1(), "rst_ld:reset2");
        rst = 1'b0;
        e          = dflt();
        e.mem_read = 1'b1;
        e.load_mdr = 1'b1;
        step(e, "late_resp:fetch2");
        mem_resp = 1'b0;
        step(e, "late_resp:fetch2_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
